// File: rtl/fsm_pkg.sv
// Shared encodings for the FSM-sharing arbiter: one-hot controller states and x/y symbol constants.
package fsm_pkg;

    typedef enum logic [3:0] {
        ARB_IDLE  = 4'b0001,
        ARB_CLR   = 4'b0010,
        ARB_BUSY  = 4'b0100,
        ARB_DRAIN = 4'b1000
    } arb_state_e;

    // Symbols are packed {x, y}
    localparam logic [1:0] SYM_X    = 2'b10;
    localparam logic [1:0] SYM_Y    = 2'b01;
    localparam logic [1:0] SYM_NONE = 2'b00;

endpackage

// File: rtl/dff.sv
// Enabled D flip-flop with asynchronous active-high reset to a parameterised value.
module dff #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= RST_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/fsm_rr_pick.sv
// Round-robin pick: rotate req so the pointer lands at bit 0, take the lowest set bit,
// then rotate the index back into requester space.
module fsm_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] pick,
    output logic [IDW-1:0]  idx
);

    localparam int SW = IDW + 1;

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IDW-1:0]    ridx;
    logic              found;
    logic [SW-1:0]     sum;

    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[NREQ-1:0];
        ridx  = '0;
        found = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                ridx  = IDW'(i);
                found = 1'b1;
            end
        end
        // ptr and ridx are both below NREQ, so a single conditional subtract wraps the sum
        sum = {1'b0, ridx} + {1'b0, ptr};
        if (sum >= SW'(NREQ))
            sum = sum - SW'(NREQ);
        idx  = sum[IDW-1:0];
        pick = found ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/fsm_share_arb.sv
// Round-robin arbiter lending one shared x/y sequence FSM to NREQ requesters, clearing it per owner.
// Optional macro BURST_LIMIT_EN caps each grant at MAX_BURST accepted symbols.
module fsm_share_arb
    import fsm_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 8,
    parameter int IDW       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] sym,
    input  logic [NREQ-1:0]   last,
    output logic [NREQ-1:0]   gnt,
    output logic              fsm_x,
    output logic              fsm_y,
    output logic              fsm_clr,
    input  logic              fsm_z,
    output logic              resp_valid,
    output logic              resp_z,
    output logic [IDW-1:0]    resp_id
);

    arb_state_e      state, state_nxt;
    logic [3:0]      state_q;
    logic [IDW-1:0]  owner, ptr, ptr_nxt;
    logic [NREQ-1:0] pick, own_onehot;
    logic [IDW-1:0]  pick_idx;
    logic            own_req, own_last;
    logic [1:0]      own_sym;
    logic            accept, at_limit;

    fsm_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req  (req),
        .ptr  (ptr),
        .pick (pick),
        .idx  (pick_idx)
    );

    dff #(.W(4), .RST_VAL(ARB_IDLE)) u_state (
        .clk(clk), .rst(rst), .en(1'b1), .d(state_nxt), .q(state_q)
    );
    assign state = arb_state_e'(state_q);

    dff #(.W(IDW)) u_owner (
        .clk(clk), .rst(rst), .en((state == ARB_IDLE) && (|pick)), .d(pick_idx), .q(owner)
    );

    // Pointer only moves when a burst completes, so each requester gets one burst per round
    assign ptr_nxt = (owner == IDW'(NREQ - 1)) ? '0 : owner + IDW'(1);
    dff #(.W(IDW)) u_ptr (
        .clk(clk), .rst(rst), .en(state == ARB_DRAIN), .d(ptr_nxt), .q(ptr)
    );

    always_comb begin
        own_req  = 1'b0;
        own_last = 1'b0;
        own_sym  = SYM_NONE;
        for (int i = 0; i < NREQ; i++) begin
            if (owner == IDW'(i)) begin
                own_req  = req[i];
                own_last = last[i];
                own_sym  = sym[2*i +: 2];
            end
        end
    end

    assign own_onehot = NREQ'(1) << owner;
    assign accept     = (state == ARB_BUSY) && own_req;

`ifdef BURST_LIMIT_EN
    localparam int CW = $clog2(MAX_BURST + 1);

    logic [CW-1:0] cnt, cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (state == ARB_DRAIN)
            cnt_nxt = '0;
        else if (accept)
            cnt_nxt = cnt + CW'(1);
    end

    dff #(.W(CW)) u_cnt (
        .clk(clk), .rst(rst), .en(1'b1), .d(cnt_nxt), .q(cnt)
    );

    // The accept that fills the burst ends it
    assign at_limit = (cnt == CW'(MAX_BURST - 1));
`else
    assign at_limit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        gnt       = '0;
        fsm_clr   = 1'b0;
        fsm_x     = 1'b0;
        fsm_y     = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (|pick)
                    state_nxt = ARB_CLR;
            end
            ARB_CLR: begin
                gnt       = own_onehot;
                fsm_clr   = 1'b1;
                state_nxt = ARB_BUSY;
            end
            ARB_BUSY: begin
                gnt = own_onehot;
                if (accept) begin
                    {fsm_x, fsm_y} = own_sym;
                    if (own_last || at_limit)
                        state_nxt = ARB_DRAIN;
                end
            end
            ARB_DRAIN: state_nxt = ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    dff #(.W(1)) u_resp_valid (
        .clk(clk), .rst(rst), .en(1'b1), .d(accept), .q(resp_valid)
    );
    dff #(.W(IDW)) u_resp_id (
        .clk(clk), .rst(rst), .en(accept), .d(owner), .q(resp_id)
    );

    // The FSM registers z on the accepting edge, so it already lines up with resp_valid
    assign resp_z = fsm_z;

endmodule

// File: tb/tb_fsm_share_arb.sv
// Bench for fsm_share_arb: shared-FSM stand-in, transaction-level model checked every cycle,
// and directed scenarios with literal expectations.
module tb_fsm_share_arb;

    localparam int NREQ = 4;
    localparam int MAXB = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [2*NREQ-1:0] sym;
    logic [NREQ-1:0]   last;
    logic [NREQ-1:0]   gnt;
    logic              fsm_x, fsm_y, fsm_clr, fsm_z;
    logic              resp_valid, resp_z;
    logic [IDW-1:0]    resp_id;

    int n_chk = 0;
    int n_err = 0;

    fsm_share_arb #(.NREQ(NREQ), .MAX_BURST(MAXB), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .req(req), .sym(sym), .last(last), .gnt(gnt),
        .fsm_x(fsm_x), .fsm_y(fsm_y), .fsm_clr(fsm_clr), .fsm_z(fsm_z),
        .resp_valid(resp_valid), .resp_z(resp_z), .resp_id(resp_id)
    );

    always #5 clk = ~clk;

    // Shared x/y FSM: S0 -x-> S2, S0 -y-> S3, S2 -y-> S1, S1/S3 -x-> S1/S2; z high in S1, S3
    function automatic int fsm_next(input int st, input logic [1:0] xy);
        int n;
        n = st;
        if (xy == 2'b10)      n = (st == 1) ? 1 : 2;
        else if (xy == 2'b01) n = (st == 2) ? 1 : 3;
        return n;
    endfunction

    function automatic logic z_of(input int st);
        return (st == 1) || (st == 3);
    endfunction

    logic fsm_rst;
    int   fsm_st;
    assign fsm_rst = rst | fsm_clr;
    always @(posedge clk or posedge fsm_rst) begin
        if (fsm_rst) fsm_st <= 0;
        else         fsm_st <= fsm_next(fsm_st, {fsm_x, fsm_y});
    end
    assign fsm_z = z_of(fsm_st);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: phase 0 waiting, 1 clearing, 2 owning, 3 releasing
    int   m_ph = 0, m_own = 0, m_ptr = 0, m_cnt = 0, m_fsm = 0, m_rid = 0;
    bit   m_rv = 0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_ph = 0; m_own = 0; m_ptr = 0; m_cnt = 0; m_fsm = 0; m_rv = 0; m_rid = 0;
        end else begin
            m_rv = 0;
            case (m_ph)
                0: begin
                    for (int k = NREQ - 1; k >= 0; k--)
                        if (req[(m_ptr + k) % NREQ]) m_own = (m_ptr + k) % NREQ;
                    if (req != 0) m_ph = 1;
                end
                1: begin m_fsm = 0; m_ph = 2; end
                2: if (req[m_own]) begin
                    m_rv  = 1;
                    m_rid = m_own;
                    m_fsm = fsm_next(m_fsm, sym[2*m_own +: 2]);
                    m_cnt++;
                    if (last[m_own]) m_ph = 3;
`ifdef BURST_LIMIT_EN
                    if (m_cnt == MAXB) m_ph = 3;
`endif
                end
                default: begin m_ptr = (m_own + 1) % NREQ; m_cnt = 0; m_ph = 0; end
            endcase
        end
    end

    initial forever begin
        logic [NREQ-1:0] eg;
        logic [1:0]      exy;
        @(negedge clk);
        eg  = '0;
        exy = 2'b00;
        if (m_ph == 1 || m_ph == 2) eg[m_own] = 1'b1;
        if (m_ph == 2 && req[m_own]) exy = sym[2*m_own +: 2];
        check("gnt", 32'(gnt), 32'(eg));
        check("fsm_clr", 32'(fsm_clr), 32'(m_ph == 1));
        check("fsm_xy", 32'({fsm_x, fsm_y}), 32'(exy));
        check("resp_valid", 32'(resp_valid), 32'(m_rv));
        if (m_rv) begin
            check("resp_id", 32'(resp_id), 32'(m_rid));
            check("resp_z", 32'(resp_z), 32'(z_of(m_fsm)));
        end
    end

    // Response log and activity counters for the directed expectations
    int rq_id[$];
    bit rq_z[$];
    int g0_cycles = 0, clr_cnt = 0;
    initial forever begin
        @(negedge clk);
        if (!rst && resp_valid) begin
            rq_id.push_back(int'(resp_id));
            rq_z.push_back(resp_z);
        end
        if (gnt[0]) g0_cycles++;
        if (fsm_clr) clr_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        rq_id.delete();
        rq_z.delete();
        g0_cycles = 0;
        clr_cnt   = 0;
    endtask

    // Requester r presents n symbols (symbol k at seq[2k+:2]), advancing after each accept
    task automatic agent(input int r, input logic [15:0] seq, input int n, input bit use_last);
        int b;
        for (int k = 0; k < n; k++) begin
            req[r] = 1'b1;
            sym[2*r +: 2] = seq[2*k +: 2];
            last[r] = use_last && (k == n - 1);
            b = 0;
            while (!(gnt[r] && !fsm_clr)) begin
                tick();
                b++;
                if (b > 300) begin
                    n_chk++; n_err++;
                    $display("FAIL agent%0d_timeout: no grant after %0d cycles", r, b);
                    req[r] = 1'b0; last[r] = 1'b0;
                    return;
                end
            end
            tick();
        end
        req[r] = 1'b0;
        last[r] = 1'b0;
        sym[2*r +: 2] = 2'b00;
    endtask

    task automatic settle();
        repeat (3) tick();
    endtask

    initial begin
        int zeros_before;
        rst = 1'b1; req = '0; sym = '0; last = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_gnt", 32'(gnt), 0);
        check("reset_resp_valid", 32'(resp_valid), 0);
        check("reset_resp_id", 32'(resp_id), 0);
        check("reset_clr", 32'(fsm_clr), 0);
        rst = 1'b0;
        clear_log();

        // 1: single owner, syms 10,01,10
        agent(0, 16'h0026, 3, 1);
        settle();
        check("t1_gnt_cycles", 32'(g0_cycles), 4);
        check("t1_clr_pulses", 32'(clr_cnt), 1);
        check("t1_nresp", 32'(rq_id.size()), 3);
        check("t1_z0", 32'(rq_z[0]), 0);
        check("t1_z1", 32'(rq_z[1]), 1);
        check("t1_z2", 32'(rq_z[2]), 1);
        check("t1_id2", 32'(rq_id[2]), 0);

        // 2: req1 and req2 together, then req0/req3 together to expose the pointer at 3
        clear_log();
        fork
            agent(1, 16'h0006, 2, 1);
            agent(2, 16'h0009, 2, 1);
        join
        settle();
        check("t2_nresp", 32'(rq_id.size()), 4);
        check("t2_first", 32'(rq_id[0]), 1);
        check("t2_third", 32'(rq_id[2]), 2);
        check("t2_clr_pulses", 32'(clr_cnt), 2);
        clear_log();
        fork
            agent(0, 16'h0002, 1, 1);
            agent(3, 16'h0002, 1, 1);
        join
        settle();
        check("t2_ptr3_first", 32'(rq_id[0]), 3);

        // 3: context isolation, req0 leaves S3 then req3 starts from S0
        clear_log();
        agent(0, 16'h0001, 1, 1);
        settle();
        agent(3, 16'h0002, 1, 1);
        settle();
        check("t3_req0_z", 32'(rq_z[0]), 1);
        check("t3_req3_z", 32'(rq_z[1]), 0);
        check("t3_req3_id", 32'(rq_id[1]), 3);

        // 6: 10 then 00 holds S2
        clear_log();
        agent(1, 16'h0002, 2, 1);
        settle();
        check("t6_z0", 32'(rq_z[0]), 0);
        check("t6_z1", 32'(rq_z[1]), 0);
        check("t6_fsm_state", 32'(fsm_st), 2);

        // 4: req0 sends 6 syms without last (plus a closing 00 with last), req1 pending
        clear_log();
        fork
            agent(0, 16'h0B66, 7, 1);
            begin tick(); agent(1, 16'h0001, 1, 1); end
        join
        settle();
        zeros_before = 0;
        begin
            bit seen = 0;
            foreach (rq_id[i]) begin
                if (rq_id[i] == 1) seen = 1;
                else if (!seen) zeros_before++;
            end
        end
        check("t4_nresp", 32'(rq_id.size()), 8);
`ifdef BURST_LIMIT_EN
        check("t4_req0_before_req1", 32'(zeros_before), 4);
        check("t4_clr_pulses", 32'(clr_cnt), 3);
`else
        check("t4_req0_before_req1", 32'(zeros_before), 7);
        check("t4_clr_pulses", 32'(clr_cnt), 2);
`endif

        // 5: move pointer to 3, then reset mid-burst
        agent(2, 16'h0002, 1, 1);
        settle();
        begin
            int b = 0;
            req[0] = 1'b1; sym[1:0] = 2'b10; last[0] = 1'b0;
            while (!(gnt[0] && !fsm_clr) && b < 300) begin tick(); b++; end
            check("t5_granted", 32'(gnt[0] && !fsm_clr), 1);
            tick();
            check("t5_pre_rv", 32'(resp_valid), 1);
            #2;
            rst = 1'b1;
            req[0] = 1'b0;
            #1;
            check("t5_async_gnt", 32'(gnt), 0);
            check("t5_async_rv", 32'(resp_valid), 0);
            check("t5_async_xy", 32'({fsm_x, fsm_y}), 0);
        end
        tick();
        tick();
        rst = 1'b0;
        clear_log();
        fork
            agent(1, 16'h0002, 1, 1);
            agent(3, 16'h0002, 1, 1);
        join
        settle();
        check("t5_lowest_first", 32'(rq_id[0]), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", n_chk, n_err);
        $fatal(1);
    end

endmodule

// File: doc/fsm_share_arb.md
Name: fsm_share_arb

Overview:
- Round-robin arbiter that shares one x/y sequence FSM between NREQ requesters.
- Grants the FSM to one owner for a burst of symbols and clears the FSM to S0 before each new owner starts.
- Returns the FSM's registered z output to the owner, tagged with the owner id.
- Sits between the requester agents and the FSM instance; the top level ORs fsm_clr into the FSM's rst.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAX_BURST, 8, maximum symbols per grant (used only with BURST_LIMIT_EN).
- IDW, 2, width of resp_id; must satisfy 2^IDW >= NREQ.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester symbol valid.
- sym  in  2*NREQ  requester i symbol; sym[2i+1]=x, sym[2i]=y.
- last  in  NREQ  marks the final symbol of requester i's burst.
- gnt  out  NREQ  one-hot grant; all zero when no owner.
- fsm_x  out  1  x to the shared FSM.
- fsm_y  out  1  y to the shared FSM.
- fsm_clr  out  1  one-cycle clear pulse to the shared FSM.
- fsm_z  in  1  registered z from the shared FSM.
- resp_valid  out  1  a response is present this cycle.
- resp_z  out  1  z result for the symbol accepted on the previous cycle.
- resp_id  out  IDW  owner index for that response.

Behaviour:
- Controller states, one-hot 4-bit: IDLE=0001, CLR=0010, BUSY=0100, DRAIN=1000.
- On rst assertion (asynchronous), the block immediately enters IDLE with:
  - gnt=0, fsm_x=0, fsm_y=0, fsm_clr=0
  - resp_valid=0, resp_id=0
  - priority pointer=0 (req0 highest), burst counter=0.
- IDLE:
  - If any req bit is set, pick the first set bit scanning from the pointer upward, wrapping modulo NREQ.
  - Register the owner and move to CLR.
  - If no req bit is set, stay in IDLE.
- CLR:
  - gnt[owner]=1, fsm_clr=1, fsm_x=fsm_y=0. No symbol is accepted.
  - Next state is BUSY.
- BUSY:
  - gnt[owner]=1. accept = req[owner].
  - When accept=1: fsm_x/fsm_y = the owner's sym and the burst counter increments. Otherwise fsm_x/fsm_y = 0.
  - If req[owner] is low, the owner keeps the grant and the block stays in BUSY (stall).
  - Accept with last[owner]=1 moves to DRAIN.
- DRAIN:
  - gnt=0, fsm_x=fsm_y=0.
  - Pointer is set to (owner+1) mod NREQ and the burst counter clears.
  - Next state is IDLE, which re-arbitrates on the following cycle.
- Response timing:
  - resp_valid(t+1) = accept(t) and resp_id(t+1) = owner, both registered.
  - resp_z = fsm_z passed through combinationally; it is meaningful only while resp_valid=1.
  - Response latency is exactly 1 cycle after acceptance.
- Symbols 00 and 11 are accepted and forwarded. The FSM holds its state, so resp_z repeats the previous z.
- Requests from non-owners are ignored, and their sym values are never forwarded.
- A requester that drops req mid-burst keeps ownership until it supplies last (or until the burst limit, when BURST_LIMIT_EN is defined).
- At most one burst per owner per arbitration round, so all active requesters are served fairly.
- Reset during any state aborts the burst. An in-flight response is discarded (resp_valid forced to 0).

Optional Feature:
- Macro: BURST_LIMIT_EN.
- Defined:
  - In BUSY, an accept that brings the burst counter to MAX_BURST moves to DRAIN even if last=0.
  - The owner must re-request to continue; its next burst starts from a cleared FSM.
- Undefined:
  - Bursts end only on last, and the counter is not synthesised.

Decomposition:
- Shared package fsm_pkg:
  - State encodings ARB_IDLE, ARB_CLR, ARB_BUSY, ARB_DRAIN.
  - Symbol constants SYM_X=2'b10, SYM_Y=2'b01, SYM_NONE=2'b00.
- Sub-module fsm_rr_pick: combinational rotate / priority-pick / rotate-back.
  - Inputs: req, pointer. Outputs: one-hot pick, index.
- State, owner, pointer and response registers use the existing dff cell with en.

Test Plan:
1. Only req0 active, syms 10, 01, 10 (last on the third):
   - gnt[0] high for 4 cycles, one fsm_clr pulse.
   - Responses z=0, 1, 1 with id=0; then gnt=0.
2. req1 and req2 both active right after reset:
   - req1 is served first (clr, burst), then req2 with its own clr pulse.
   - Pointer ends at 3.
3. Context isolation:
   - req0 burst 01 (leaves FSM in S3, z=1); then req3 sends 10.
   - req3 gets resp_z=0 (S0 to S2), not 1.
4. With BURST_LIMIT_EN, MAX_BURST=4, req0 sends 6 symbols with no last while req1 is pending:
   - After 4 accepts, gnt moves to req1.
   - Without the macro, all 6 are accepted first.
5. rst asserted in BUSY mid-burst:
   - gnt=0 and resp_valid=0 without waiting for a clock edge.
   - Next grant goes to the lowest-index active req.
6. Owner sends 10 then 00:
   - The second response repeats z=0 and the FSM stays in S2.
